// File: rtl/spi_byte_master.sv
// Byte-wide SPI master: valid/ready byte intake, configurable CPOL/CPHA/bit order,
// with chip select held low across a burst until a byte marked last has shifted.
module spi_byte_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       i2c_wb_clk_i,
  input  logic       i2c_wb_rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_n_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_e;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [4:0] edge_q, edge_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       last_q, last_d;
  logic       rxv_q, rxv_d;
  logic [7:0] txsr_q, txsr_d;
  logic [7:0] rxsr_q, rxsr_d;
  logic [7:0] rxd_q, rxd_d;

  logic       hs;
  logic       tick;
  logic       smp;
  logic [7:0] rx_nxt;

  function automatic logic first_bit(input logic [7:0] b);
    return MSB_FIRST ? b[7] : b[0];
  endfunction

  function automatic logic [7:0] shl(input logic [7:0] b);
    return MSB_FIRST ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
  endfunction

  assign tx_ready_o = (state_q == IDLE) || (state_q == GAP);
  assign busy_o     = (state_q != IDLE);
  assign cs_n_o     = (state_q == IDLE);
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign rx_data_o  = rxd_q;
  assign rx_valid_o = rxv_q;

  assign hs   = tx_valid_i & tx_ready_o;
  assign tick = (div_q == 8'd0);
  // edge_q+1 is the edge about to be produced; odd edges sample when CPHA=0
  assign smp  = (~edge_q[0]) ^ CPHA;
  assign rx_nxt = MSB_FIRST ? {rxsr_q[6:0], miso_i}
                            : {miso_i, rxsr_q[7:1]};

  always_comb begin
    state_d = state_q;
    div_d   = (div_q != 8'd0) ? div_q - 8'd1 : div_q;
    edge_d  = edge_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    last_d  = last_q;
    txsr_d  = txsr_q;
    rxsr_d  = rxsr_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (hs) begin
          state_d = LEAD;
          div_d   = DIV_LD;
          edge_d  = 5'd0;
          last_d  = tx_last_i;
          if (CPHA) begin
            txsr_d = tx_data_i;
          end else begin
            mosi_d = first_bit(tx_data_i);
            txsr_d = shl(tx_data_i);
          end
        end
      end
      LEAD, SHIFT: begin
        if (tick) begin
          state_d = SHIFT;
          div_d   = DIV_LD;
          sck_d   = ~sck_q;
          edge_d  = edge_q + 5'd1;
          if (smp) begin
            rxsr_d = rx_nxt;
          end else if (edge_q != 5'd15) begin
            mosi_d = first_bit(txsr_q);
            txsr_d = shl(txsr_q);
          end
          if (edge_q == 5'd15) begin
            rxv_d   = 1'b1;
            rxd_d   = smp ? rx_nxt : rxsr_q;
            state_d = last_q ? TRAIL : GAP;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d = IDLE;
          div_d   = DIV_LD;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      edge_q  <= 5'd0;
      sck_q   <= CPOL;
      mosi_q  <= 1'b0;
      last_q  <= 1'b0;
      rxv_q   <= 1'b0;
      txsr_q  <= 8'h00;
      rxsr_q  <= 8'h00;
      rxd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      last_q  <= last_d;
      rxv_q   <= rxv_d;
      txsr_q  <= txsr_d;
      rxsr_q  <= rxsr_d;
      rxd_q   <= rxd_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: four configurations, each with an SPI slave
// model and a per-byte scoreboard driven by directed and random bytes.
module tb_spi_byte_master;

  localparam int NI = 4;
  localparam int DIVS [NI] = '{4, 4, 1, 2};
  localparam bit POLS [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit PHAS [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit MSBS [NI] = '{1'b1, 1'b1, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    txd   [NI];
  logic [7:0]    rxd   [NI];
  logic [7:0]    sb_nx [NI];
  logic [NI-1:0] txv, txl, rdy, rxv, busy, sck, mosi, cs, miso;
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_u
    localparam int D = DIVS[g];
    localparam bit P = POLS[g];
    localparam bit H = PHAS[g];
    localparam bit M = MSBS[g];

    int         edges = 0;
    int         hs_c = 0;
    int         rx_c = 0;
    logic       psck = 1'b0;
    logic       pcs = 1'b1;
    logic       act = 1'b0;
    logic       pend = 1'b0;
    logic       skip = 1'b1;
    logic       clast = 1'b0;
    logic       exp_rise;
    logic [7:0] mb = 8'h00;
    logic [7:0] ctx = 8'h00;
    logic [7:0] csb = 8'h00;

    spi_byte_master #(
      .CLK_DIV  (D),
      .CPOL     (P),
      .CPHA     (H),
      .MSB_FIRST(M)
    ) u_dut (
      .i2c_wb_clk_i(clk),
      .i2c_wb_rst_i(rst),
      .tx_data_i   (txd[g]),
      .tx_valid_i  (txv[g]),
      .tx_last_i   (txl[g]),
      .tx_ready_o  (rdy[g]),
      .rx_data_o   (rxd[g]),
      .rx_valid_o  (rxv[g]),
      .busy_o      (busy[g]),
      .sck_o       (sck[g]),
      .mosi_o      (mosi[g]),
      .miso_i      (miso[g]),
      .cs_n_o      (cs[g])
    );

    function automatic string t(input string s);
      return $sformatf("u%0d.%s", g, s);
    endfunction

    // Slave shifts on the non-sampling edge; index = bits already shifted
    function automatic int bit_idx(input int e);
      int k;
      k = H ? ((e > 0) ? (e - 1) / 2 : 0) : e / 2;
      return (k > 7) ? 7 : k;
    endfunction

    assign miso[g] = M ? csb[7 - bit_idx(edges)] : csb[bit_idx(edges)];

    always @(negedge clk) begin
      if (rst) begin
        act   = 1'b0;
        pend  = 1'b0;
        edges = 0;
        skip  = 1'b1;
      end else if (skip) begin
        skip = 1'b0;
        chk(t("rst_cs"), cs[g], 1'b1);
        chk(t("rst_sck"), sck[g], P);
        chk(t("rst_mosi"), mosi[g], 1'b0);
        chk(t("rst_rdy"), rdy[g], 1'b1);
        chk(t("rst_rxv"), rxv[g], 1'b0);
        chk(t("rst_rxd"), rxd[g], 8'h00);
        chk(t("rst_busy"), busy[g], 1'b0);
      end else begin
        if (sck[g] !== psck) begin
          edges++;
          if (((edges % 2) == 1) ^ H)
            mb = M ? {mb[6:0], mosi[g]} : {mosi[g], mb[7:1]};
        end
        if (rxv[g]) begin
          chk(t("rx_act"), act, 1'b1);
          chk(t("rx_data"), rxd[g], csb);
          chk(t("mosi_byte"), mb, ctx);
          chk(t("edges"), edges, 16);
          chk(t("rx_lat"), cyc - hs_c, 1 + 16 * D);
          chk(t("sck_end"), sck[g], P);
          chk(t("cs_low"), cs[g], 1'b0);
          chk(t("rdy_after"), rdy[g], !clast);
          pend = clast;
          rx_c = cyc;
          act  = 1'b0;
        end else if (act && cyc > hs_c) begin
          chk(t("rdy_busy"), rdy[g], 1'b0);
        end
        if (pend && cyc > rx_c && cyc < rx_c + D)
          chk(t("rdy_trail"), rdy[g], 1'b0);
        exp_rise = pend && (cyc == rx_c + D);
        if (exp_rise) begin
          chk(t("cs_rise"), cs[g], 1'b1);
          chk(t("mosi_idle"), mosi[g], 1'b0);
          chk(t("rdy_idle"), rdy[g], 1'b1);
          pend = 1'b0;
        end
        if (cs[g] && !pcs)
          chk(t("cs_rise_exp"), exp_rise, 1'b1);
        if (!cs[g] && pcs)
          chk(t("cs_fall"), act && (cyc == hs_c + 1), 1'b1);
        if (txv[g] && rdy[g]) begin
          act   = 1'b1;
          hs_c  = cyc;
          ctx   = txd[g];
          csb   = sb_nx[g];
          clast = txl[g];
          edges = 0;
          mb    = 8'h00;
        end
      end
      psck = sck[g];
      pcs  = cs[g];
    end
  end

  task automatic send(input int i, input logic [7:0] d, input logic l,
                      input logic [7:0] s);
    int n;
    n = 0;
    txd[i]   = d;
    txl[i]   = l;
    sb_nx[i] = s;
    txv[i]   = 1'b1;
    @(negedge clk);
    while (!rdy[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d.hs_wait", i), (n < 500), 1'b1);
    @(posedge clk);
    #1;
    txv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d.idle_wait", i), (n < 2000), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!rxv[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d.rx_wait", i), (n < 2000), 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gp;
    logic l;
    txv = '0;
    txl = '0;
    for (int i = 0; i < NI; i++) begin
      txd[i]   = 8'h00;
      sb_nx[i] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(0, 8'hA5, 1'b1, 8'h3C);
    wait_idle(0);
    chk("u0.rxd_hold", rxd[0], 8'h3C);

    send(1, 8'h81, 1'b1, 8'hFF);
    wait_idle(1);
    chk("u1.sck_after", sck[1], 1'b1);
    chk("u1.rxd_hold", rxd[1], 8'hFF);

    send(0, 8'h12, 1'b0, 8'hC8);
    send(0, 8'h34, 1'b1, 8'h5E);
    wait_idle(0);

    send(0, 8'h5A, 1'b1, 8'hC3);
    txd[0] = 8'hFF;
    txv[0] = 1'b1;
    wait_rx(0);
    txv[0] = 1'b0;
    wait_idle(0);

    send(0, 8'h96, 1'b1, 8'h69);
    repeat (28) @(posedge clk);
    #1;
    rst    = 1'b1;
    txd[1] = 8'hEE;
    txv[1] = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    txv[1] = 1'b0;
    chk("u0.abort_cs", cs[0], 1'b1);
    chk("u0.abort_sck", sck[0], 1'b0);
    chk("u0.abort_mosi", mosi[0], 1'b0);
    chk("u1.rst_hs", busy[1], 1'b0);
    repeat (80) @(posedge clk);
    #1;
    chk("u1.rst_hs_late", busy[1], 1'b0);
    send(0, 8'hE7, 1'b1, 8'h1B);
    wait_idle(0);

    send(2, 8'h01, 1'b1, 8'hB4);
    wait_idle(2);

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 6; k++) begin
        l = (k == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        send(i, 8'($urandom), l, 8'($urandom));
        if (l) wait_idle(i);
        gp = $urandom_range(0, 3);
        if (gp > 0) begin
          repeat (gp) @(posedge clk);
          #1;
        end
      end
    end

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
